inst_fetch_queue: RTL and testbench
===================================

# inst_fetch_queue

Instruction fetch front end that sits directly upstream of the instruction AXI read adapter and directly downstream of its response path. It owns the fetch PC, issues one word request at a time on the adapter's `address`/`address_valid`/`address_read_ready` handshake, and buffers returned words in a DEPTH-entry FIFO. It presents the buffered words to if_id on a valid/ready interface. It also handles branch/exception redirects (`flush`) by discarding stale in-flight responses.

## Interface
- `DEPTH`, 4: FIFO entries. Must be a power of two and at least 2.
- `RESET_PC`, 32'hBFC0_0000: fetch PC after reset.

- `clk` in 1: the single clock; everything is sampled on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `flush` in 1: redirect request, single cycle.
- `flush_target` in 32: new fetch PC, sampled when `flush`=1.
- `req_address` out 32: to adapter `address`. Unmapped virtual PC.
- `req_valid` out 1: to adapter `address_valid`.
- `req_accepted` in 1: from adapter `address_read_ready`.
- `resp_valid` in 1: from adapter `data_valid`.
- `resp_data` in 32: from adapter `data`.
- `resp_address` in 32: from adapter `data_address`.
- `out_valid` out 1: head entry valid toward if_id.
- `out_inst` out 32: head instruction. Driven 0 when `out_valid`=0.
- `out_pc` out 32: head PC. Driven 0 when `out_valid`=0.
- `out_ready` in 1: if_id consumes the head when `out_valid`&&`out_ready`.

## Operation
- State consists of the following registers:
  - `pc`: 32 bits.
  - FIFO read/write pointers: log2(DEPTH)+1 bits each. The extra bit is a wrap bit, so full and empty are distinguishable.
  - `inflight`: 0/1. Set when `req_valid` first rises. Cleared on `resp_valid`.
  - `discard`: 0/1. Indicates the next response is stale.
- Request side states:
  - IDLE (`req_valid`=0, `inflight`=0)
  - REQ (`req_valid`=1)
  - WAIT (`req_valid`=0, `inflight`=1)
- Transitions:
  - IDLE→REQ when occupancy + `inflight` < DEPTH, `discard`=0 and `flush`=0.
  - REQ→WAIT on `req_accepted`. At the same time `pc` <= `pc`+4, with 32-bit wrap and no carry out.
  - WAIT→IDLE on `resp_valid`. WAIT→REQ directly on that edge if credit allows, giving back-to-back requests.
- `req_address` = `pc`. It stays stable while `req_valid`=1.
- `req_valid`, once raised, is held until `req_accepted`, even across a flush, because the adapter has already latched the address.
- Push: on an edge with `resp_valid`=1, `discard`=0 and `flush`=0, write {`resp_address`, `resp_data`} at the write pointer.
- Overflow is impossible by the credit rule. If `resp_valid` arrives with no request in flight, the response is ignored.
- Pop: when `out_valid`&&`out_ready`, advance the read pointer.
- Simultaneous push and pop are allowed in any occupancy state.
- Flush (highest priority, evaluated on the edge with `flush`=1):
  - FIFO emptied (pointers equal). Any pop that cycle is moot.
  - `pc` <= `flush_target`. This overrides the +4 even if `req_accepted` fires the same cycle.
  - `discard` <= 1 if a request is in flight and no `resp_valid` arrives this cycle.
  - `discard` <= 0 if `resp_valid` arrives this cycle. That response is dropped.
  - `discard` <= 0 if nothing is in flight.
- A response arriving with `discard`=1 is dropped and clears `discard`.
- A flush arriving while `discard`=1 keeps `discard`=1.
- `flush_target` low bits are passed through unchanged. Alignment faults are detected downstream.

## Timing
- Reset values: `pc`=`RESET_PC`, `req_address`=`RESET_PC`, `req_valid`=0, `out_valid`=0, `out_inst`=0, `out_pc`=0, `inflight`=0, `discard`=0, FIFO empty.
- First `req_valid` rises on the first rising edge after `reset` deasserts.
- Push to `out_valid`: 1 cycle. A word pushed at edge N is visible after edge N.
- `resp_valid` to the next `req_valid`: 0 extra cycles, since the new request is registered on the same edge.
- Flush to new-target request:
  - 1 edge if nothing is in flight.
  - Otherwise the edge of the stale response.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous). Responses arriving during reset are ignored.

## Test plan
- **Cold fetch:** release reset, adapter model accepts after 2 cycles and responds 3 cycles later with 0x2402_0001, `out_ready`=1 → `req_address`=0xBFC0_0000, then `out_valid` with `out_pc`=0xBFC0_0000 and `out_inst`=0x2402_0001, then the next request at 0xBFC0_0004.
- **Backpressure:** `out_ready`=0 with DEPTH=4 → exactly 4 requests issued (0xBFC0_0000–0xBFC0_000C), then `req_valid` stays 0. Raise `out_ready` → words drain in order and issue resumes at 0xBFC0_0010.
- **Flush with in-flight request:** flush to 0x8000_0100 while in WAIT → FIFO empties next cycle, the pending response is dropped, next `req_address`=0x8000_0100, and its word is the first to reach `out_valid`.
- **Flush coincident with `resp_valid` and `req_accepted`:** the response is not pushed, `discard` stays 0, and `pc`=target (not target+4 or old+4).
- **Wrap-around:** stream 12 words with `out_ready` toggling every cycle → all 12 arrive in order with correct PCs, pointers wrap 3 times, and no loss or duplication.
- **Reset mid-WAIT:** assert `reset` during WAIT → outputs go to reset values immediately. After release, fetch restarts at 0xBFC0_0000 with an empty FIFO.

Source files
------------

// File: rtl/inst_fetch_queue.sv
// Instruction fetch front end: owns the fetch PC, issues one word request at a
// time to the instruction read adapter and buffers returned words in a FIFO.
module inst_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic [31:0] flush_target,
  output logic [31:0] req_address,
  output logic        req_valid,
  input  logic        req_accepted,
  input  logic        resp_valid,
  input  logic [31:0] resp_data,
  input  logic [31:0] resp_address,
  output logic        out_valid,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  input  logic        out_ready
);
  localparam int          AW         = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C    = (AW + 1)'(DEPTH);
  localparam logic [AW:0] DEPTH_M1_C = (AW + 1)'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } req_state_e;

  req_state_e  state_r, state_next_s;
  logic [31:0] pc_r, pc_next_s;
  logic        redirected_r, redirected_next_s;
  logic        discard_r, discard_next_s;
  logic [AW:0] wr_ptr_r, rd_ptr_r;
  logic [AW:0] wr_ptr_next_s, rd_ptr_next_s, count_s;
  logic [63:0] mem_r [DEPTH];
  logic        inflight_s, resp_take_s, push_s, pop_s;
  logic        empty_next_s, head_bypass_s;
  logic [63:0] head_next_s;
  logic        req_valid_r, out_valid_r;
  logic [31:0] req_address_r, out_inst_r, out_pc_r;

  assign inflight_s  = (state_r != IDLE);
  assign resp_take_s = resp_valid && (state_r == WAIT);
  assign count_s     = wr_ptr_r - rd_ptr_r;

  // Request FSM next state, fetch PC and stale-response tracking
  always_comb begin
    state_next_s      = state_r;
    pc_next_s         = pc_r;
    redirected_next_s = 1'b0;
    discard_next_s    = discard_r;
    case (state_r)
      IDLE: begin
        if (!flush && !discard_r && (count_s < DEPTH_C)) state_next_s = REQ;
        else state_next_s = IDLE;
      end
      REQ: begin
        if (req_accepted) begin
          state_next_s = WAIT;
        end else begin
          state_next_s      = REQ;
          redirected_next_s = redirected_r | flush;
        end
      end
      WAIT: begin
        // the arriving word occupies one slot, hence DEPTH-1
        if (resp_valid && !flush && (count_s < DEPTH_M1_C)) state_next_s = REQ;
        else if (resp_valid) state_next_s = IDLE;
        else state_next_s = WAIT;
      end
      default: state_next_s = IDLE;
    endcase
    // a flush seen while the old address is still presented must not be undone by +4
    if (flush) pc_next_s = flush_target;
    else if ((state_r == REQ) && req_accepted && !redirected_r) pc_next_s = pc_r + 32'd4;
    else pc_next_s = pc_r;
    if (flush) discard_next_s = inflight_s && !resp_take_s;
    else if (resp_take_s) discard_next_s = 1'b0;
    else discard_next_s = discard_r;
  end

  // FIFO pointer updates and next head entry for the registered outputs
  always_comb begin
    push_s        = resp_take_s && !discard_r && !flush;
    pop_s         = out_valid_r && out_ready && !flush;
    wr_ptr_next_s = wr_ptr_r + {{AW{1'b0}}, push_s};
    if (flush) rd_ptr_next_s = wr_ptr_r;
    else rd_ptr_next_s = rd_ptr_r + {{AW{1'b0}}, pop_s};
    empty_next_s  = (wr_ptr_next_s == rd_ptr_next_s);
    head_bypass_s = push_s && (rd_ptr_next_s == wr_ptr_r);
    if (head_bypass_s) head_next_s = {resp_address, resp_data};
    else head_next_s = mem_r[rd_ptr_next_s[AW-1:0]];
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= IDLE;
      pc_r          <= RESET_PC;
      redirected_r  <= 1'b0;
      discard_r     <= 1'b0;
      wr_ptr_r      <= '0;
      rd_ptr_r      <= '0;
      req_valid_r   <= 1'b0;
      req_address_r <= RESET_PC;
      out_valid_r   <= 1'b0;
      out_inst_r    <= 32'h0;
      out_pc_r      <= 32'h0;
    end else begin
      state_r      <= state_next_s;
      pc_r         <= pc_next_s;
      redirected_r <= redirected_next_s;
      discard_r    <= discard_next_s;
      wr_ptr_r     <= wr_ptr_next_s;
      rd_ptr_r     <= rd_ptr_next_s;
      req_valid_r  <= (state_next_s == REQ);
      if ((state_r == REQ) && (state_next_s == REQ)) req_address_r <= req_address_r;
      else req_address_r <= pc_next_s;
      out_valid_r  <= !empty_next_s;
      out_inst_r   <= empty_next_s ? 32'h0 : head_next_s[31:0];
      out_pc_r     <= empty_next_s ? 32'h0 : head_next_s[63:32];
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r[AW-1:0]] <= {resp_address, resp_data};
  end

  assign req_valid   = req_valid_r;
  assign req_address = req_address_r;
  assign out_valid   = out_valid_r;
  assign out_inst    = out_inst_r;
  assign out_pc      = out_pc_r;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: fixed vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_inst_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [31:0] flush_target;
  logic [31:0] req_address;
  logic        req_valid;
  logic        req_accepted;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic [31:0] resp_address;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_ready;

  always #5 clk = ~clk;

  inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .flush(flush), .flush_target(flush_target),
    .req_address(req_address), .req_valid(req_valid), .req_accepted(req_accepted),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_address(resp_address),
    .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc), .out_ready(out_ready)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: FIFO as a queue, request as pending/outstanding flags.
  logic [63:0] m_fifo[$];
  bit          m_req, m_wait, m_stale;
  logic [31:0] m_addr, m_next;
  int          m_epoch, m_req_epoch;

  // Adapter model and observation logs
  bit          ad_busy;
  int          ad_cnt, acc_cnt;
  logic [31:0] ad_addr;
  logic [31:0] accs_q[$];
  logic [63:0] pops_q[$];

  typedef struct {
    logic        flush;
    logic [31:0] target;
    logic        acc;
    logic        rv;
    logic [31:0] rdata;
    logic [31:0] raddr;
    logic        ordy;
    logic        e_rv;
    logic [31:0] e_ra;
    logic        e_ov;
    logic [31:0] e_inst;
    logic [31:0] e_pc;
  } vec_t;
  vec_t tbl[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_fifo.delete();
    m_req = 1'b0; m_wait = 1'b0; m_stale = 1'b0;
    m_addr = RESET_PC; m_next = RESET_PC;
    m_epoch = 0; m_req_epoch = 0;
  endfunction

  function automatic void model_step();
    int occ;
    bit was_idle, take, pop, push;
    occ      = m_fifo.size();
    was_idle = !m_req && !m_wait;
    take     = resp_valid && m_wait;
    pop      = (occ > 0) && out_ready && !flush;
    push     = take && !m_stale && !flush;
    if (flush) m_stale = (m_req || m_wait) && !take;
    else if (take) m_stale = 1'b0;
    if (flush) m_fifo.delete();
    else begin
      if (pop) void'(m_fifo.pop_front());
      if (push) m_fifo.push_back({resp_address, resp_data});
    end
    if (m_req && req_accepted) begin
      m_req  = 1'b0;
      m_wait = 1'b1;
      if (!flush && (m_req_epoch == m_epoch)) m_next = m_addr + 32'd4;
    end
    if (take) m_wait = 1'b0;
    if (flush) begin
      m_next = flush_target;
      m_epoch++;
    end
    if ((was_idle || take) && !flush && ((occ + (take ? 1 : 0)) < DEPTH)) begin
      m_req       = 1'b1;
      m_addr      = m_next;
      m_req_epoch = m_epoch;
    end
  endfunction

  task automatic check_model();
    logic [63:0] head;
    head = (m_fifo.size() > 0) ? m_fifo[0] : 64'h0;
    check("req_valid", 32'(req_valid), 32'(m_req));
    check("req_address", req_address, m_req ? m_addr : m_next);
    check("out_valid", 32'(out_valid), 32'(m_fifo.size() > 0));
    check("out_inst", out_inst, head[31:0]);
    check("out_pc", out_pc, head[63:32]);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic drive_adapter(input int acc_max, input int rsp_max);
    req_accepted = 1'b0; resp_valid = 1'b0; resp_data = 32'h0; resp_address = 32'h0;
    if (ad_busy) begin
      if (ad_cnt == 0) begin
        resp_valid = 1'b1; resp_address = ad_addr; resp_data = ad_addr ^ 32'h5A5A_0000;
        ad_busy = 1'b0;
      end else ad_cnt--;
    end else if (req_valid) begin
      if (acc_cnt < 0) acc_cnt = int'($urandom_range(acc_max, 0));
      if (acc_cnt == 0) begin
        req_accepted = 1'b1; ad_addr = req_address; ad_busy = 1'b1;
        ad_cnt = int'($urandom_range(rsp_max, 0)); acc_cnt = -1;
      end else acc_cnt--;
    end
  endtask

  task automatic step(input int acc_max, input int rsp_max);
    drive_adapter(acc_max, rsp_max);
    if (out_valid && out_ready && !flush) pops_q.push_back({out_pc, out_inst});
    if (req_valid && req_accepted) accs_q.push_back(req_address);
    cycle();
  endtask

  task automatic do_reset();
    reset = 1'b1; flush = 1'b0; flush_target = 32'h0; req_accepted = 1'b0;
    resp_valid = 1'b1; resp_data = 32'hFFFF_FFFF; resp_address = 32'hFFFF_FFFF; out_ready = 1'b1;
    ad_busy = 1'b0; acc_cnt = -1; ad_cnt = 0;
    #1;
    check("rst.req_valid", 32'(req_valid), 32'd0);
    check("rst.req_address", req_address, RESET_PC);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.out_inst", out_inst, 32'h0);
    check("rst.out_pc", out_pc, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("rst.hold_req_valid", 32'(req_valid), 32'd0);
    check("rst.hold_out_valid", 32'(out_valid), 32'd0);
    reset = 1'b0; resp_valid = 1'b0; resp_data = 32'h0; resp_address = 32'h0;
    model_reset();
    accs_q.delete();
    pops_q.delete();
  endtask

  initial begin
    // flush, target, acc, rv, rdata, raddr, ordy | req_valid, req_address, out_valid, out_inst, out_pc
    tbl[0]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'hBFC0_0000, 1'b0, 32'h0, 32'h0};
    tbl[1]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'hBFC0_0000, 1'b0, 32'h0, 32'h0};
    tbl[2]  = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'hBFC0_0004, 1'b0, 32'h0, 32'h0};
    tbl[3]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'hBFC0_0004, 1'b0, 32'h0, 32'h0};
    tbl[4]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'hBFC0_0004, 1'b0, 32'h0, 32'h0};
    tbl[5]  = '{1'b0, 32'h0, 1'b0, 1'b1, 32'h2402_0001, 32'hBFC0_0000, 1'b1,
                1'b1, 32'hBFC0_0004, 1'b1, 32'h2402_0001, 32'hBFC0_0000};
    tbl[6]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'hBFC0_0004, 1'b0, 32'h0, 32'h0};
    tbl[7]  = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'hBFC0_0008, 1'b0, 32'h0, 32'h0};
    tbl[8]  = '{1'b0, 32'h0, 1'b0, 1'b1, 32'h3C1D_0001, 32'hBFC0_0004, 1'b0,
                1'b1, 32'hBFC0_0008, 1'b1, 32'h3C1D_0001, 32'hBFC0_0004};
    tbl[9]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0,
                1'b1, 32'hBFC0_0008, 1'b1, 32'h3C1D_0001, 32'hBFC0_0004};
    tbl[10] = '{1'b1, 32'h8000_0100, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1,
                1'b1, 32'hBFC0_0008, 1'b0, 32'h0, 32'h0};
    tbl[11] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h8000_0100, 1'b0, 32'h0, 32'h0};
    tbl[12] = '{1'b0, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'hBFC0_0008, 1'b1,
                1'b1, 32'h8000_0100, 1'b0, 32'h0, 32'h0};
    tbl[13] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h8000_0104, 1'b0, 32'h0, 32'h0};
    tbl[14] = '{1'b0, 32'h0, 1'b0, 1'b1, 32'h1111_2222, 32'h8000_0100, 1'b0,
                1'b1, 32'h8000_0104, 1'b1, 32'h1111_2222, 32'h8000_0100};
    tbl[15] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h8000_0104, 1'b0, 32'h0, 32'h0};

    // Cold fetch, stale-response flush, fixed vectors
    do_reset();
    for (int i = 0; i < 16; i++) begin
      flush = tbl[i].flush; flush_target = tbl[i].target; req_accepted = tbl[i].acc;
      resp_valid = tbl[i].rv; resp_data = tbl[i].rdata; resp_address = tbl[i].raddr;
      out_ready = tbl[i].ordy;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d.req_valid", i), 32'(req_valid), 32'(tbl[i].e_rv));
      check($sformatf("vec%0d.req_address", i), req_address, tbl[i].e_ra);
      check($sformatf("vec%0d.out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
      check($sformatf("vec%0d.out_inst", i), out_inst, tbl[i].e_inst);
      check($sformatf("vec%0d.out_pc", i), out_pc, tbl[i].e_pc);
    end

    // Backpressure: exactly DEPTH requests, then in-order drain and resume
    do_reset();
    out_ready = 1'b0;
    repeat (40) step(1, 2);
    check("bp.requests", 32'(accs_q.size()), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) begin
      logic [31:0] a;
      a = (accs_q.size() > i) ? accs_q[i] : 32'h0;
      check($sformatf("bp.req_addr%0d", i), a, RESET_PC + 32'(4 * i));
    end
    check("bp.stalled_req_valid", 32'(req_valid), 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 60 && (accs_q.size() < DEPTH + 1 || pops_q.size() < DEPTH); i++) step(1, 2);
    for (int i = 0; i < DEPTH; i++) begin
      logic [63:0] w;
      w = (pops_q.size() > i) ? pops_q[i] : 64'h0;
      check($sformatf("bp.pop_pc%0d", i), w[63:32], RESET_PC + 32'(4 * i));
    end
    begin
      logic [31:0] a;
      a = (accs_q.size() > DEPTH) ? accs_q[DEPTH] : 32'h0;
      check("bp.resume_addr", a, 32'hBFC0_0010);
    end

    // Flush coincident with a response and a stray accept while waiting
    do_reset();
    out_ready = 1'b1;
    begin
      bit hit;
      logic [63:0] w;
      hit = 1'b0;
      for (int i = 0; i < 40 && !hit; i++) begin
        drive_adapter(1, 2);
        if (resp_valid) begin
          flush = 1'b1; flush_target = 32'h8000_0200; req_accepted = 1'b1; hit = 1'b1;
        end
        cycle();
        flush = 1'b0;
      end
      check("coinc.found", 32'(hit), 32'd1);
      check("coinc.out_valid", 32'(out_valid), 32'd0);
      check("coinc.req_valid", 32'(req_valid), 32'd0);
      step(1, 2);
      check("coinc.new_req_valid", 32'(req_valid), 32'd1);
      check("coinc.new_req_addr", req_address, 32'h8000_0200);
      pops_q.delete();
      for (int i = 0; i < 40 && pops_q.size() == 0; i++) step(1, 2);
      w = (pops_q.size() > 0) ? pops_q[0] : 64'h0;
      check("coinc.first_pc", w[63:32], 32'h8000_0200);
      check("coinc.first_inst", w[31:0], 32'h8000_0200 ^ 32'h5A5A_0000);
    end

    // Wrap-around: 12 words with out_ready toggling every cycle
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 300 && pops_q.size() < 12; i++) begin
      out_ready = ~out_ready;
      step(0, 0);
    end
    check("wrap.count", 32'(pops_q.size()), 32'd12);
    for (int i = 0; i < 12; i++) begin
      logic [63:0] w;
      w = (pops_q.size() > i) ? pops_q[i] : 64'h0;
      check($sformatf("wrap.pc%0d", i), w[63:32], RESET_PC + 32'(4 * i));
      check($sformatf("wrap.inst%0d", i), w[31:0], (RESET_PC + 32'(4 * i)) ^ 32'h5A5A_0000);
    end

    // Reset asserted mid-WAIT, then a clean restart
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 30 && !(ad_busy && ad_cnt > 0 && out_valid); i++) step(0, 3);
    check("rstwait.in_wait", 32'(ad_busy && !req_valid), 32'd1);
    #2;
    do_reset();
    out_ready = 1'b1;
    step(1, 2);
    check("rstwait.restart_valid", 32'(req_valid), 32'd1);
    check("rstwait.restart_addr", req_address, RESET_PC);
    check("rstwait.empty", 32'(out_valid), 32'd0);

    // Randomized traffic against the reference model
    do_reset();
    repeat (3000) begin
      out_ready    = ($urandom_range(3, 0) != 0);
      flush        = ($urandom_range(19, 0) == 0);
      flush_target = $urandom;
      step(3, 4);
    end
    flush = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
